// File: rtl/vdma_frame_addr_gen.sv
// rtl/vdma_frame_addr_gen.sv - per-frame burst/line address generator rotating across frame buffers
module vdma_frame_addr_gen #(
    parameter int    ASIZE          = 29,
    parameter int    BURST_MAP_ADDR = 12800,
    parameter int    LASIZE         = 16,
    parameter int    NUM_FB         = 3,
    parameter int    LCSIZE         = 12,
    parameter string MODE           = "ALIGN",
    localparam int   FBW            = (NUM_FB > 1) ? $clog2(NUM_FB) : 1
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [NUM_FB*ASIZE-1:0] fb_base,
    input  logic [ASIZE-1:0]        line_stride,
    input  logic [LCSIZE-1:0]       lines_per_frame,
    input  logic                    burst_done,
    input  logic                    tail_done,
    output logic [ASIZE-1:0]        out_addr,
    output logic [FBW-1:0]          fb_index,
    output logic [LCSIZE-1:0]       line_cnt,
    output logic                    line_end,
    output logic                    frame_end,
    output logic                    busy
);

    localparam bit             USE_STRIDE = (MODE == "STRIDE");
    localparam logic [ASIZE-1:0] BURST_INC = ASIZE'(BURST_MAP_ADDR);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state_q, state_n;
    logic               burst_q, burst_d, tail_q, tail_d;
    logic [ASIZE-1:0]   addr_q, addr_n, ls_q, ls_n, stride_q, stride_n, jump;
    logic [LCSIZE-1:0]  lpf_q, lpf_n, cnt_q, cnt_n, cnt_inc;
    logic [FBW-1:0]     idx_q, idx_n, idx_adv;
    logic               le_q, le_n, fe_q, fe_n;
    logic               burst_rise, tail_rise;

    // Padded to a power of two so any fb_index value selects a defined entry
    logic [ASIZE-1:0]   base_arr [2**FBW];

    for (genvar g = 0; g < 2**FBW; g++) begin : g_base
        if (g < NUM_FB) begin : g_used
            assign base_arr[g] = fb_base[g*ASIZE +: ASIZE];
        end else begin : g_pad
            assign base_arr[g] = '0;
        end
    end

    assign burst_rise = burst_q & ~burst_d;
    assign tail_rise  = tail_q & ~tail_d;
    assign cnt_inc    = cnt_q + LCSIZE'(1);
    assign idx_adv    = (idx_q == FBW'(NUM_FB - 1)) ? '0 : idx_q + FBW'(1);
    assign jump       = USE_STRIDE ? ls_q + stride_q
                                   : {addr_q[ASIZE-1:LASIZE], {LASIZE{1'b0}}} + stride_q;

    always_comb begin
        state_n  = state_q;
        addr_n   = addr_q;
        ls_n     = ls_q;
        stride_n = stride_q;
        lpf_n    = lpf_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        le_n     = 1'b0;
        fe_n     = 1'b0;
        if (frame_start) begin
            // Restart always reuses the current buffer, even mid-frame
            state_n  = ACTIVE;
            addr_n   = base_arr[idx_q];
            ls_n     = base_arr[idx_q];
            cnt_n    = '0;
            stride_n = line_stride;
            lpf_n    = lines_per_frame;
        end else if (state_q == ACTIVE) begin
            if (tail_rise) begin
                cnt_n = cnt_inc;
                le_n  = 1'b1;
                if ((lpf_q != '0) && (cnt_inc == lpf_q)) begin
                    fe_n    = 1'b1;
                    state_n = IDLE;
                    idx_n   = idx_adv;
                    addr_n  = base_arr[idx_adv];
                    ls_n    = base_arr[idx_adv];
                end else begin
                    addr_n = jump;
                    ls_n   = jump;
                end
            end else if (burst_rise) begin
                addr_n = addr_q + BURST_INC;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= IDLE;
            burst_q  <= 1'b0;
            burst_d  <= 1'b0;
            tail_q   <= 1'b0;
            tail_d   <= 1'b0;
            addr_q   <= '0;
            ls_q     <= '0;
            stride_q <= '0;
            lpf_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            le_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            burst_q  <= burst_done;
            burst_d  <= burst_q;
            tail_q   <= tail_done;
            tail_d   <= tail_q;
            addr_q   <= addr_n;
            ls_q     <= ls_n;
            stride_q <= stride_n;
            lpf_q    <= lpf_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            le_q     <= le_n;
            fe_q     <= fe_n;
        end
    end

    assign out_addr  = addr_q;
    assign fb_index  = idx_q;
    assign line_cnt  = cnt_q;
    assign line_end  = le_q;
    assign frame_end = fe_q;
    assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_vdma_frame_addr_gen.sv
// tb/tb_vdma_frame_addr_gen.sv - self-checking bench for vdma_frame_addr_gen (ALIGN and STRIDE instances)
module tb_vdma_frame_addr_gen;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [86:0]   fb_base;
    logic [28:0]   line_stride;
    logic [11:0]   lines_per_frame;
    logic          burst_done = 1'b0;
    logic          tail_done = 1'b0;

    logic [28:0]   a_addr, s_addr;
    logic [1:0]    a_idx, s_idx;
    logic [11:0]   a_cnt, s_cnt;
    logic          a_le, a_fe, a_busy, s_le, s_fe, s_busy;

    always #5 clock = ~clock;

    vdma_frame_addr_gen #(.MODE("ALIGN")) dut (
        .clock(clock), .rst(rst), .frame_start(frame_start), .fb_base(fb_base),
        .line_stride(line_stride), .lines_per_frame(lines_per_frame),
        .burst_done(burst_done), .tail_done(tail_done),
        .out_addr(a_addr), .fb_index(a_idx), .line_cnt(a_cnt),
        .line_end(a_le), .frame_end(a_fe), .busy(a_busy)
    );

    vdma_frame_addr_gen #(.MODE("STRIDE")) dut_s (
        .clock(clock), .rst(rst), .frame_start(frame_start), .fb_base(fb_base),
        .line_stride(line_stride), .lines_per_frame(lines_per_frame),
        .burst_done(burst_done), .tail_done(tail_done),
        .out_addr(s_addr), .fb_index(s_idx), .line_cnt(s_cnt),
        .line_end(s_le), .frame_end(s_fe), .busy(s_busy)
    );

    // op: 0 frame_start, 1 burst pulse x reps, 2 tail pulse, 3 idle cycle
    typedef struct {
        int          op;
        int          reps;
        logic [28:0] addr;
        logic [28:0] addr_s;
        logic [1:0]  idx;
        logic [11:0] cnt;
        logic        le;
        logic        fe;
        logic        busy;
    } vec_t;

    typedef struct {
        string       name;
        logic [28:0] addr;
        logic [28:0] addr_s;
        logic [1:0]  idx;
        logic [11:0] cnt;
        logic        le;
        logic        fe;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   vectors = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_burst();
        burst_done = 1'b1; tick();
        burst_done = 1'b0; tick();
    endtask

    task automatic do_tail();
        tail_done = 1'b1; tick();
        tail_done = 1'b0; tick();
    endtask

    task automatic do_fs();
        frame_start = 1'b1; tick();
        frame_start = 1'b0;
    endtask

    task automatic push(input string name, input logic [28:0] addr, input logic [28:0] addr_s,
                        input logic [1:0] idx, input logic [11:0] cnt,
                        input logic le, input logic fe, input logic busy);
        exp_t e;
        e.name = name; e.addr = addr; e.addr_s = addr_s; e.idx = idx;
        e.cnt = cnt; e.le = le; e.fe = fe; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty queue at check");
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "out_addr",   {3'b0, a_addr},  {3'b0, e.addr});
        cmp(e.name, "out_addr_s", {3'b0, s_addr},  {3'b0, e.addr_s});
        cmp(e.name, "fb_index",   {30'b0, a_idx},  {30'b0, e.idx});
        cmp(e.name, "fb_index_s", {30'b0, s_idx},  {30'b0, e.idx});
        cmp(e.name, "line_cnt",   {20'b0, a_cnt},  {20'b0, e.cnt});
        cmp(e.name, "line_end",   {31'b0, a_le},   {31'b0, e.le});
        cmp(e.name, "frame_end",  {31'b0, a_fe},   {31'b0, e.fe});
        cmp(e.name, "busy",       {31'b0, a_busy}, {31'b0, e.busy});
        cmp(e.name, "busy_s",     {31'b0, s_busy}, {31'b0, e.busy});
    endtask

    initial begin
        tbl[0]  = '{0, 1, 29'h1000000, 29'h1000000, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1, 1, 29'h1003200, 29'h1003200, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1, 1, 29'h1006400, 29'h1006400, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1, 1, 29'h1009600, 29'h1009600, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{2, 1, 29'h1010000, 29'h1010000, 2'd0, 12'd1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1, 1, 29'h1013200, 29'h1013200, 2'd0, 12'd1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{2, 1, 29'h2000000, 29'h2000000, 2'd1, 12'd2, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{0, 1, 29'h2000000, 29'h2000000, 2'd1, 12'd0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1, 6, 29'h2012C00, 29'h2012C00, 2'd1, 12'd0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{2, 1, 29'h2020000, 29'h2010000, 2'd1, 12'd1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{2, 1, 29'h3000000, 29'h3000000, 2'd2, 12'd2, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{3, 1, 29'h3000000, 29'h3000000, 2'd2, 12'd2, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{0, 1, 29'h3000000, 29'h3000000, 2'd2, 12'd0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{2, 1, 29'h3010000, 29'h3010000, 2'd2, 12'd1, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{2, 1, 29'h1000000, 29'h1000000, 2'd0, 12'd2, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1, 1, 29'h1000000, 29'h1000000, 2'd0, 12'd2, 1'b0, 1'b0, 1'b0};

        fb_base         = {29'h3000000, 29'h2000000, 29'h1000000};
        line_stride     = 29'h10000;
        lines_per_frame = 12'd2;

        tick(); tick();
        push("reset", 29'h0, 29'h0, 2'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            case (tbl[i].op)
                0: do_fs();
                1: for (int r = 0; r < tbl[i].reps; r++) do_burst();
                2: do_tail();
                default: tick();
            endcase
            push($sformatf("vec%0d", i), tbl[i].addr, tbl[i].addr_s, tbl[i].idx,
                 tbl[i].cnt, tbl[i].le, tbl[i].fe, tbl[i].busy);
            check_out();
        end

        // Held burst level counts once
        do_fs();
        burst_done = 1'b1;
        repeat (10) tick();
        burst_done = 1'b0;
        tick();
        push("held_burst", 29'h1003200, 29'h1003200, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1);
        check_out();

        // Coincident burst and tail: only the line jump applies
        burst_done = 1'b1; tail_done = 1'b1; tick();
        burst_done = 1'b0; tail_done = 1'b0; tick();
        push("burst_tail", 29'h1010000, 29'h1010000, 2'd0, 12'd1, 1'b1, 1'b0, 1'b1);
        check_out();

        // Restart coincident with the frame-ending tail rise
        do_burst();
        push("pre_restart", 29'h1013200, 29'h1013200, 2'd0, 12'd1, 1'b0, 1'b0, 1'b1);
        check_out();
        tail_done = 1'b1; tick();
        tail_done = 1'b0; frame_start = 1'b1; tick();
        frame_start = 1'b0;
        push("restart", 29'h1000000, 29'h1000000, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1);
        check_out();
        tick();
        push("restart_hold", 29'h1000000, 29'h1000000, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1);
        check_out();

        // Reset mid-frame
        do_tail();
        rst = 1'b1; tick();
        rst = 1'b0;
        push("mid_reset", 29'h0, 29'h0, 2'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        // Address wrap and free-running line count
        fb_base[28:0]   = 29'h1FFFFF00;
        lines_per_frame = 12'd0;
        do_fs();
        push("wrap_start", 29'h1FFFFF00, 29'h1FFFFF00, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1);
        check_out();
        do_burst();
        push("wrap_burst", 29'h0003100, 29'h0003100, 2'd0, 12'd0, 1'b0, 1'b0, 1'b1);
        check_out();
        do_tail();
        push("free_line1", 29'h0010000, 29'h000FF00, 2'd0, 12'd1, 1'b1, 1'b0, 1'b1);
        check_out();
        do_tail();
        push("free_line2", 29'h0020000, 29'h001FF00, 2'd0, 12'd2, 1'b1, 1'b0, 1'b1);
        check_out();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
